sisa_run_controller: RTL and testbench
======================================

Name: sisa_run_controller

Overview:
Host-facing run controller for the sISA core. It loads a program into the 16x8 instruction RAM over a byte stream while holding the core in reset. It then sequences execution by gating the core's clock enable: free run with a cycle budget, single step, breakpoint on PC, self-loop (halt idiom) detection, and host halt. It sits between the host/testbench command interface and the core's PC/register-file enables and instruction-RAM write port.

Parameters:
ADDR_W, 4, instruction address / PC width
DATA_W, 8, instruction word width
CNT_W, 16, width of cycle budget and cycle counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&&ready
cmd_op  in  2  00 LOAD, 01 RUN, 10 STEP, 11 HALT
cmd_arg  in  CNT_W  LOAD: word count-1 in [ADDR_W-1:0]; RUN: cycle budget (0 = unlimited)
load_valid  in  1  program byte valid
load_ready  out  1  controller accepts program byte
load_data  in  DATA_W  program byte
bp_en  in  1  breakpoint enable
bp_addr  in  ADDR_W  breakpoint PC
pc  in  ADDR_W  current core PC
core_en  out  1  core PC/register-file update enable
core_rst  out  1  holds core PC at 0, active-high
imem_we  out  1  instruction RAM write strobe
imem_addr  out  ADDR_W  instruction RAM write address
imem_wdata  out  DATA_W  instruction RAM write data
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on completion of LOAD/RUN/STEP
stop_cause  out  2  00 budget/step, 01 breakpoint, 10 self-loop, 11 host halt
cycle_count  out  CNT_W  enabled core cycles since last LOAD, saturating

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, core_rst=1. core_en, imem_we, imem_addr, load_ready, busy, done, stop_cause and cycle_count all 0. Reset mid-LOAD/RUN aborts immediately; no done.
- States: IDLE, LOAD, RUN, STEP.
- IDLE: cmd_ready=1. LOAD goes to LOAD, with word counter=0, cycle_count=0, core_rst=1. RUN goes to RUN and latches the budget. STEP goes to STEP. HALT in IDLE is consumed with no effect.
- LOAD: load_ready=1 and cmd_ready=0. imem_we=load_valid. imem_addr=word counter. imem_wdata=load_data (combinational). Each accepted byte increments the counter.
  - After the byte at address cmd_arg[ADDR_W-1:0] is accepted: IDLE next cycle, done pulses in that cycle.
  - N=16 is valid; the counter does not wrap past N.
  - core_rst stays 1 until the next RUN/STEP is accepted.
- RUN: core_rst=0, cmd_ready=1. core_en is combinational: 1 unless a stop condition holds this cycle. When a stop condition holds: core_en=0, go to IDLE, done pulses next cycle, stop_cause is registered.
- Stop conditions, highest priority first:
  - host halt: cmd_valid && cmd_op==11 in this cycle. Non-HALT commands in RUN are consumed and ignored.
  - breakpoint: bp_en && pc==bp_addr, except on the first RUN cycle, so a run can resume from a breakpoint.
  - self-loop: pc equals the registered previous pc and core_en was 1 in the previous cycle.
  - budget: budget!=0 and enabled-cycle count in this run == budget. Exactly B enabled cycles occur for budget B.
- STEP: core_rst=0, core_en=1 for exactly one cycle, then IDLE. done pulses, stop_cause=00. Breakpoint and self-loop are not checked.
- cycle_count increments on every core_en=1 cycle and saturates at all-ones.
- stop_cause holds until the next stop. done never asserts in the same cycle as busy rising.

Test Plan:
- LOAD arg=2, bytes 0x85,0x92,0x01 with load_valid gaps -> imem_we only on valid cycles at addr 0,1,2 with matching data; done one cycle after third byte; core_rst=1 throughout and after.
- RUN budget=5, pc counting 0..4 -> core_en high exactly 5 cycles; cycle_count=5; stop_cause=00; done pulse; busy low afterwards.
- bp_en=1, bp_addr=3, RUN budget=0, pc counting -> core_en high for pc 0,1,2, low at pc=3; stop_cause=01. Then RUN budget=1 -> one enabled cycle at pc=3, stop_cause=00.
- RUN budget=0, pc goes 6,7,7 -> core_en=1 at first pc=7, 0 at second; stop_cause=10; cycle_count=2 (from LOAD).
- RUN budget=0, HALT issued after 10 enabled cycles -> core_en=0 in the handshake cycle; stop_cause=11; cycle_count=10; a simultaneous breakpoint match still reports 11.
- Assert reset low mid-LOAD after 2 bytes -> all outputs at reset values immediately. Re-LOAD -> writes restart at addr 0.

Source files
------------

// File: rtl/sisa_run_controller_if.sv
// Host-side command and program-load channels of the sISA run controller.
// The controller takes the slave view; the host or testbench drives the master view.
interface sisa_run_controller_if #(
  parameter int CNT_W  = 16,
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [CNT_W-1:0]  cmd_arg;
  logic              load_valid;
  logic              load_ready;
  logic [DATA_W-1:0] load_data;

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, load_valid, load_data,
    output cmd_ready, load_ready
  );

  modport master (
    output cmd_valid, cmd_op, cmd_arg, load_valid, load_data,
    input  cmd_ready, load_ready
  );
endinterface

// File: rtl/sisa_run_controller.sv
// sISA run controller: streams a program into instruction RAM with the core held in reset,
// then gates the core clock enable for budgeted runs, single steps and the various stop causes.
module sisa_run_controller #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  sisa_run_controller_if.slave host,
  input  logic                 bp_en,
  input  logic [ADDR_W-1:0]    bp_addr,
  input  logic [ADDR_W-1:0]    pc,
  output logic                 core_en,
  output logic                 core_rst,
  output logic                 imem_we,
  output logic [ADDR_W-1:0]    imem_addr,
  output logic [DATA_W-1:0]    imem_wdata,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           stop_cause,
  output logic [CNT_W-1:0]     cycle_count
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_STEP} state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  localparam logic [1:0] CAUSE_BUDGET = 2'b00;
  localparam logic [1:0] CAUSE_BP     = 2'b01;
  localparam logic [1:0] CAUSE_LOOP   = 2'b10;
  localparam logic [1:0] CAUSE_HALT   = 2'b11;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] wcnt, last;
  logic [CNT_W-1:0]  budget, run_cnt;
  logic              first_cyc;
  logic [ADDR_W-1:0] prev_pc;
  logic              prev_en;
  logic              stop;
  logic [1:0]        cause_nx;
  logic              cmd_fire, load_fire;
  logic              halt_hit, bp_hit, loop_hit, budget_hit;

  assign host.cmd_ready  = (state == S_IDLE) || (state == S_RUN);
  assign host.load_ready = (state == S_LOAD);
  assign cmd_fire        = host.cmd_valid && host.cmd_ready;
  assign load_fire       = host.load_valid && (state == S_LOAD);

  assign imem_we    = load_fire;
  assign imem_addr  = wcnt;
  assign imem_wdata = host.load_data;
  assign busy       = (state != S_IDLE);

  // The first run cycle skips the breakpoint so a run can resume from the PC it stopped on.
  assign halt_hit   = cmd_fire && (host.cmd_op == OP_HALT);
  assign bp_hit     = bp_en && (pc == bp_addr) && !first_cyc;
  assign loop_hit   = prev_en && (pc == prev_pc);
  assign budget_hit = (budget != '0) && (run_cnt == budget);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    core_en  = 1'b0;
    stop     = 1'b0;
    cause_nx = CAUSE_BUDGET;
    unique case (state)
      S_IDLE: begin
        if (cmd_fire) begin
          case (host.cmd_op)
            OP_LOAD: state_nx = S_LOAD;
            OP_RUN:  state_nx = S_RUN;
            OP_STEP: state_nx = S_STEP;
            default: ;
          endcase
        end
      end
      S_LOAD: begin
        if (load_fire && (wcnt == last)) state_nx = S_IDLE;
      end
      S_RUN: begin
        stop = 1'b1;
        if (halt_hit)        cause_nx = CAUSE_HALT;
        else if (bp_hit)     cause_nx = CAUSE_BP;
        else if (loop_hit)   cause_nx = CAUSE_LOOP;
        else if (budget_hit) cause_nx = CAUSE_BUDGET;
        else                 stop     = 1'b0;
        core_en = !stop;
        if (stop) state_nx = S_IDLE;
      end
      S_STEP: begin
        core_en  = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wcnt        <= '0;
      last        <= '0;
      budget      <= '0;
      run_cnt     <= '0;
      first_cyc   <= 1'b0;
      prev_pc     <= '0;
      prev_en     <= 1'b0;
      core_rst    <= 1'b1;
      done        <= 1'b0;
      stop_cause  <= CAUSE_BUDGET;
      cycle_count <= '0;
    end else begin
      prev_pc <= pc;
      prev_en <= core_en;
      done    <= 1'b0;
      if (core_en && (cycle_count != '1)) cycle_count <= cycle_count + CNT_W'(1);
      unique case (state)
        S_IDLE: begin
          if (cmd_fire) begin
            case (host.cmd_op)
              OP_LOAD: begin
                wcnt        <= '0;
                last        <= host.cmd_arg[ADDR_W-1:0];
                cycle_count <= '0;
                core_rst    <= 1'b1;
              end
              OP_RUN: begin
                budget    <= host.cmd_arg;
                run_cnt   <= '0;
                first_cyc <= 1'b1;
                core_rst  <= 1'b0;
              end
              OP_STEP: core_rst <= 1'b0;
              default: ;
            endcase
          end
        end
        S_LOAD: begin
          // Counter parks on the last address so a full 2^ADDR_W load never wraps.
          if (load_fire) begin
            if (wcnt == last) done <= 1'b1;
            else              wcnt <= wcnt + ADDR_W'(1);
          end
        end
        S_RUN: begin
          first_cyc <= 1'b0;
          if (core_en) run_cnt <= run_cnt + CNT_W'(1);
          if (stop) begin
            done       <= 1'b1;
            stop_cause <= cause_nx;
          end
        end
        S_STEP: begin
          done       <= 1'b1;
          stop_cause <= CAUSE_BUDGET;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sisa_run_controller.sv
// Directed bench for sisa_run_controller: a cycle-level model of the run rules is checked
// against the DUT on every falling edge, alongside hand-computed expectations per scenario.
module tb_sisa_run_controller;
  localparam int AW = 4, DW = 8, CW = 16;
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_STEP = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          bp_en = 1'b0;
  logic [AW-1:0] bp_addr = '0;
  logic [AW-1:0] pc = '0;
  logic          core_en, core_rst, imem_we, busy, done;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_wdata;
  logic [1:0]    stop_cause;
  logic [CW-1:0] cycle_count;

  sisa_run_controller_if #(.CNT_W(CW), .DATA_W(DW)) host();

  sisa_run_controller #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .host(host),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
    .core_en(core_en), .core_rst(core_rst), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .stop_cause(stop_cause), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state describes the cycle currently being observed; it advances after each compare.
  int m_mode, m_waddr, m_last, m_budget, m_ran, m_cyc, m_cause, m_prev_pc;
  bit m_first, m_prev_en, m_done, m_crst;

  task automatic m_reset();
    m_mode = M_IDLE; m_waddr = 0; m_last = 0; m_budget = 0; m_ran = 0;
    m_cyc = 0; m_cause = 0; m_prev_pc = 0;
    m_first = 0; m_prev_en = 0; m_done = 0; m_crst = 1;
  endtask

  always @(negedge clk) begin
    int e_en, e_we, e_cr, e_lr, stp, cause;
    if (!reset) begin
      m_reset();
      chk("rst_core_rst", core_rst, 1);
      chk("rst_core_en", core_en, 0);
      chk("rst_imem_we", imem_we, 0);
      chk("rst_imem_addr", imem_addr, 0);
      chk("rst_load_ready", host.load_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_stop_cause", stop_cause, 0);
      chk("rst_cycle_count", cycle_count, 0);
    end else begin
      e_en = 0; e_we = 0; stp = 0; cause = m_cause;
      e_cr = (m_mode == M_IDLE || m_mode == M_RUN) ? 1 : 0;
      e_lr = (m_mode == M_LOAD) ? 1 : 0;
      if (m_mode == M_RUN) begin
        stp = 1;
        if (host.cmd_valid && host.cmd_op == 2'd3)                   cause = 3;
        else if (bp_en && pc == bp_addr && !m_first)                 cause = 1;
        else if (m_prev_en && int'(pc) == m_prev_pc)                 cause = 2;
        else if (m_budget != 0 && m_ran == m_budget)                 cause = 0;
        else stp = 0;
        e_en = stp ? 0 : 1;
      end else if (m_mode == M_STEP) e_en = 1;
      if (m_mode == M_LOAD) e_we = host.load_valid ? 1 : 0;

      chk("m_core_en", core_en, e_en);
      chk("m_imem_we", imem_we, e_we);
      chk("m_cmd_ready", host.cmd_ready, e_cr);
      chk("m_load_ready", host.load_ready, e_lr);
      chk("m_busy", busy, (m_mode != M_IDLE) ? 1 : 0);
      chk("m_done", done, m_done);
      chk("m_stop_cause", stop_cause, m_cause);
      chk("m_cycle_count", cycle_count, m_cyc);
      chk("m_core_rst", core_rst, m_crst);
      if (m_mode == M_LOAD) chk("m_imem_addr", imem_addr, m_waddr);
      if (e_we != 0) chk("m_imem_wdata", imem_wdata, host.load_data);

      m_done = 0;
      if (e_en != 0 && m_cyc < 65535) m_cyc++;
      case (m_mode)
        M_IDLE: if (host.cmd_valid) begin
          case (host.cmd_op)
            2'd0: begin m_mode = M_LOAD; m_waddr = 0; m_last = int'(host.cmd_arg[3:0]); m_cyc = 0; m_crst = 1; end
            2'd1: begin m_mode = M_RUN; m_budget = int'(host.cmd_arg); m_ran = 0; m_first = 1; m_crst = 0; end
            2'd2: begin m_mode = M_STEP; m_crst = 0; end
            default: ;
          endcase
        end
        M_LOAD: if (host.load_valid) begin
          if (m_waddr == m_last) begin m_mode = M_IDLE; m_done = 1; end
          else m_waddr++;
        end
        M_RUN: begin
          m_first = 0;
          if (e_en != 0) m_ran++;
          if (stp != 0) begin m_mode = M_IDLE; m_done = 1; m_cause = cause; end
        end
        default: begin m_mode = M_IDLE; m_done = 1; m_cause = 0; end
      endcase
      m_prev_pc = int'(pc);
      m_prev_en = (e_en != 0);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [15:0] arg);
    host.cmd_valid = 1'b1; host.cmd_op = op; host.cmd_arg = arg;
    tick();
    host.cmd_valid = 1'b0;
  endtask

  initial begin
    host.cmd_valid = 1'b0; host.cmd_op = '0; host.cmd_arg = '0;
    host.load_valid = 1'b0; host.load_data = '0;
    @(negedge clk);
    chk("init_core_rst", core_rst, 1);
    chk("init_busy", busy, 0);
    tick(); reset = 1'b1; tick();

    // LOAD three words with a valid gap
    cmd(2'd0, 16'd2);
    host.load_valid = 1; host.load_data = 8'h85;
    @(negedge clk); chk("ld0_addr", imem_addr, 0); chk("ld0_we", imem_we, 1); tick();
    host.load_valid = 0;
    @(negedge clk); chk("ld_gap_we", imem_we, 0); tick();
    host.load_valid = 1; host.load_data = 8'h92;
    @(negedge clk); chk("ld1_addr", imem_addr, 1); chk("ld1_data", imem_wdata, 8'h92); tick();
    host.load_data = 8'h01;
    @(negedge clk); chk("ld2_addr", imem_addr, 2); tick();
    host.load_valid = 0;
    @(negedge clk); chk("ld_done", done, 1); chk("ld_busy", busy, 0); chk("ld_core_rst", core_rst, 1); tick();

    // RUN budget 5
    pc = 0; cmd(2'd1, 16'd5);
    for (int i = 0; i < 5; i++) begin
      pc = 4'(i); @(negedge clk); chk("run5_en", core_en, 1); tick();
    end
    pc = 5; @(negedge clk); chk("run5_stop_en", core_en, 0); tick();
    @(negedge clk); chk("run5_done", done, 1); chk("run5_cause", stop_cause, 0);
    chk("run5_count", cycle_count, 5); chk("run5_busy", busy, 0); tick();

    // breakpoint at 3, then resume one cycle from it
    bp_en = 1; bp_addr = 3; pc = 0; cmd(2'd1, 16'd0);
    for (int i = 0; i < 3; i++) begin
      pc = 4'(i); @(negedge clk); chk("bp_run_en", core_en, 1); tick();
    end
    pc = 3; @(negedge clk); chk("bp_hit_en", core_en, 0); tick();
    @(negedge clk); chk("bp_cause", stop_cause, 1); chk("bp_count", cycle_count, 8); tick();
    cmd(2'd1, 16'd1);
    @(negedge clk); chk("bp_resume_en", core_en, 1); tick();
    pc = 4; @(negedge clk); chk("bp_resume_stop", core_en, 0); tick();
    @(negedge clk); chk("bp_resume_cause", stop_cause, 0); chk("bp_resume_count", cycle_count, 9); tick();
    bp_en = 0;

    // self-loop: pc 6,7,7
    cmd(2'd0, 16'd0);
    host.load_valid = 1; host.load_data = 8'h3C; tick(); host.load_valid = 0;
    @(negedge clk); chk("ld1w_count", cycle_count, 0); tick();
    pc = 6; cmd(2'd1, 16'd0);
    @(negedge clk); chk("loop_en6", core_en, 1); tick();
    pc = 7; @(negedge clk); chk("loop_en7a", core_en, 1); tick();
    @(negedge clk); chk("loop_en7b", core_en, 0); tick();
    @(negedge clk); chk("loop_cause", stop_cause, 2); chk("loop_count", cycle_count, 2); tick();

    // HALT in IDLE has no effect; single STEP
    cmd(2'd3, 16'd0);
    @(negedge clk); chk("idle_halt_busy", busy, 0); chk("idle_halt_done", done, 0);
    chk("idle_halt_cause", stop_cause, 2); tick();
    pc = 11; cmd(2'd2, 16'd0);
    @(negedge clk); chk("step_en", core_en, 1); tick();
    @(negedge clk); chk("step_done", done, 1); chk("step_cause", stop_cause, 0); chk("step_count", cycle_count, 3); tick();

    // host HALT after 10 cycles, coincident with a breakpoint match; stray RUN ignored
    cmd(2'd0, 16'd0);
    host.load_valid = 1; tick(); host.load_valid = 0; tick();
    bp_en = 1; bp_addr = 10; pc = 0; cmd(2'd1, 16'd0);
    for (int i = 0; i < 10; i++) begin
      pc = 4'(i);
      if (i == 5) begin host.cmd_valid = 1; host.cmd_op = 2'd1; host.cmd_arg = 16'd3; end
      @(negedge clk); chk("halt_run_en", core_en, 1); tick();
      host.cmd_valid = 0;
    end
    pc = 10; host.cmd_valid = 1; host.cmd_op = 2'd3;
    @(negedge clk); chk("halt_en", core_en, 0); chk("halt_ready", host.cmd_ready, 1); tick();
    host.cmd_valid = 0;
    @(negedge clk); chk("halt_cause", stop_cause, 3); chk("halt_count", cycle_count, 10); chk("halt_done", done, 1); tick();
    bp_en = 0;

    // full 16-word load
    cmd(2'd0, 16'd15);
    for (int i = 0; i < 16; i++) begin
      host.load_valid = 1; host.load_data = 8'(i * 7 + 1);
      if (i == 15) begin @(negedge clk); chk("ld16_last_addr", imem_addr, 15); end
      tick();
    end
    host.load_valid = 0;
    @(negedge clk); chk("ld16_done", done, 1); chk("ld16_core_rst", core_rst, 1); tick();

    // reset mid-LOAD, then reload from address 0
    cmd(2'd0, 16'd5);
    host.load_valid = 1; host.load_data = 8'hAA; tick();
    host.load_data = 8'hBB; tick();
    host.load_data = 8'hCC; #2; reset = 1'b0; #1;
    chk("arst_busy", busy, 0); chk("arst_we", imem_we, 0); chk("arst_lr", host.load_ready, 0);
    chk("arst_core_rst", core_rst, 1); chk("arst_cause", stop_cause, 0); chk("arst_addr", imem_addr, 0);
    tick(); host.load_valid = 0; reset = 1'b1; tick();
    cmd(2'd0, 16'd1);
    host.load_valid = 1; host.load_data = 8'h11;
    @(negedge clk); chk("reld_addr0", imem_addr, 0); chk("reld_we", imem_we, 1); tick();
    host.load_data = 8'h22;
    @(negedge clk); chk("reld_addr1", imem_addr, 1); tick();
    host.load_valid = 0;
    @(negedge clk); chk("reld_done", done, 1); tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
